// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave backed by a 32-bit SRAM with a configurable number of wait states.
// Misaligned or oversized transfers receive a two-cycle ERROR response and leave memory untouched.
module ahb_lite_sram_slave #(
  parameter int P_ADDR_WIDTH = 10,
  parameter int P_WAIT       = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADYin,
  output logic [31:0] HRDATA,
  output logic [1:0]  HRESP,
  output logic        HREADYout
);
  localparam int DEPTH = 1 << P_ADDR_WIDTH;
  localparam logic [2:0] WAIT_LOAD = 3'(P_WAIT);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t                  state_reg, state_next;
  logic [2:0]              cnt_reg, cnt_next;
  logic                    active_reg, active_next;
  logic [P_ADDR_WIDTH+1:0] addr_reg;
  logic                    write_reg;
  logic [2:0]              size_reg;

  logic                    ready_now;
  logic                    capture;
  logic                    illegal;
  logic                    complete;
  logic                    wen;
  logic [3:0]              be;
  logic [P_ADDR_WIDTH-1:0] wr_idx;
  logic [P_ADDR_WIDTH-1:0] rd_idx;
  logic [31:0]             rdata_word;
  logic                    unused_ok;

  assign unused_ok = ^{HBURST, HADDR[31:P_ADDR_WIDTH+2], HTRANS[0]};

  assign ready_now = (state_reg == ST_IDLE) || (state_reg == ST_ERR2);
  assign HREADYout = ready_now;
  assign HRESP     = ((state_reg == ST_ERR1) || (state_reg == ST_ERR2)) ? 2'b01 : 2'b00;
  assign capture   = HSEL && HREADYin && HTRANS[1] && ready_now;

  // active_reg marks a legal data phase; it completes in ST_IDLE
  assign complete = (state_reg == ST_IDLE) && active_reg;
  assign wen      = complete && write_reg;
  assign HRDATA   = (complete && !write_reg) ? rdata_word : 32'h0;

  always_comb begin
    illegal = 1'b0;
    case (HSIZE)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = HADDR[0];
      3'b010:  illegal = |HADDR[1:0];
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    active_next = active_reg;
    case (state_reg)
      ST_WAIT: begin
        cnt_next = cnt_reg - 3'd1;
        if (cnt_reg <= 3'd1) state_next = ST_IDLE;
      end
      ST_ERR1: state_next = ST_ERR2;
      default: begin
        state_next  = ST_IDLE;
        active_next = 1'b0;
        if (capture) begin
          if (illegal) begin
            state_next = ST_ERR1;
          end else begin
            active_next = 1'b1;
            if (P_WAIT > 0) begin
              state_next = ST_WAIT;
              cnt_next   = WAIT_LOAD;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= 3'd0;
      active_reg <= 1'b0;
      addr_reg   <= '0;
      write_reg  <= 1'b0;
      size_reg   <= 3'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      active_reg <= active_next;
      if (capture) begin
        addr_reg  <= HADDR[P_ADDR_WIDTH+1:0];
        write_reg <= HWRITE;
        size_reg  <= HSIZE;
      end
    end
  end

  always_comb begin
    be = 4'b0000;
    case (size_reg)
      3'b000:  be[addr_reg[1:0]] = 1'b1;
      3'b001:  be = addr_reg[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Read the incoming address on a capture edge so zero-wait reads have data next cycle
  assign wr_idx = addr_reg[P_ADDR_WIDTH+1:2];
  assign rd_idx = capture ? HADDR[P_ADDR_WIDTH+1:2] : wr_idx;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_byte_reg;

    always_ff @(posedge HCLK) begin
      if (wen && be[gi]) mem[wr_idx] <= HWDATA[8*gi +: 8];
      // forward a same-edge write so a following read sees it without a bubble
      if (wen && be[gi] && (wr_idx == rd_idx)) rd_byte_reg <= HWDATA[8*gi +: 8];
      else                                      rd_byte_reg <= mem[rd_idx];
    end

    assign rdata_word[8*gi +: 8] = rd_byte_reg;
  end
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: four instances (P_WAIT 0..3) on one bus, pipelined driver
// with a scoreboard fed from a byte-level reference memory.
`timescale 1ns/1ps
module tb_ahb_lite_sram_slave;
  logic             hclk = 1'b0;
  logic             hresetn;
  logic             hsel;
  logic [31:0]      haddr;
  logic [1:0]       htrans;
  logic             hwrite;
  logic [2:0]       hsize;
  logic [2:0]       hburst;
  logic [31:0]      hwdata;
  logic [3:0]       hsel_v;
  logic [3:0]       hready_v;
  logic [3:0][1:0]  hresp_v;
  logic [3:0][31:0] hrdata_v;
  int               target = 0;
  int               errors = 0;
  int               checks = 0;

  always #5 hclk = ~hclk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    assign hsel_v[gi] = hsel && (target == gi);
    ahb_lite_sram_slave #(.P_ADDR_WIDTH(10), .P_WAIT(gi)) u_dut (
      .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel_v[gi]), .HADDR(haddr),
      .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
      .HWDATA(hwdata), .HREADYin(hready_v[gi]), .HRDATA(hrdata_v[gi]),
      .HRESP(hresp_v[gi]), .HREADYout(hready_v[gi])
    );
  end

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    bit          active;
    bit          write;
    bit          err;
    bit          check_rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  txn_t        stim_q[$];
  exp_t        exp_q[$];
  logic [31:0] model [int];

  // Queue one address phase for the current target and its expected data-phase outcome
  task automatic push(input bit sel, input logic [1:0] trans, input bit write,
                      input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    txn_t t;
    exp_t e;
    int key, nbytes, lane;
    logic [31:0] word;
    t.sel = sel; t.trans = trans; t.write = write; t.addr = addr; t.size = size; t.wdata = data;
    e.active = sel && trans[1];
    e.write = write; e.err = 1'b0; e.check_rdata = 1'b0;
    e.addr = addr; e.wdata = data; e.rdata = 32'h0; e.waits = 0;
    if (e.active) begin
      key = target * 4096 + int'(addr[11:2]);
      if (size > 3'd2) begin
        e.err = 1'b1;
      end else begin
        nbytes = 1 << int'(size);
        if ((int'(addr[1:0]) % nbytes) != 0) e.err = 1'b1;
      end
      if (e.err) begin
        e.waits = 1;
      end else begin
        e.waits = target;
        if (write) begin
          word = model.exists(key) ? model[key] : 32'h0;
          for (int k = 0; k < nbytes; k++) begin
            lane = int'(addr[1:0]) + k;
            word[8*lane +: 8] = data[8*lane +: 8];
          end
          model[key] = word;
        end else if (model.exists(key)) begin
          e.check_rdata = 1'b1;
          e.rdata = model[key];
        end
      end
    end
    stim_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic drive_idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0; hsize = 3'd0;
    hburst = 3'd0; hwdata = 32'hFFFF_FFFF;
  endtask

  // Pipelined master: drives queued address phases, checks every cycle against the scoreboard
  task automatic run_bus();
    exp_t dp, e;
    txn_t t;
    bit dp_valid;
    int waits, guard;
    logic rdy;
    logic [1:0] rsp;
    logic [31:0] rd;
    dp_valid = 1'b0; waits = 0; guard = 0;
    while ((stim_q.size() > 0 || dp_valid) && guard < 500) begin
      guard++;
      if (stim_q.size() > 0) begin
        t = stim_q[0];
        hsel = t.sel; htrans = t.trans; hwrite = t.write; haddr = t.addr; hsize = t.size;
      end else begin
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0; hsize = 3'd0;
      end
      hburst = 3'($urandom_range(0, 7));
      hwdata = (dp_valid && dp.write) ? dp.wdata : 32'hFFFF_FFFF;
      @(negedge hclk);
      rdy = hready_v[target]; rsp = hresp_v[target]; rd = hrdata_v[target];
      checks++;
      if (dp_valid) begin
        if (rsp !== (dp.err ? 2'b01 : 2'b00)) begin
          errors++;
          $display("FAIL hresp t%0d addr=%h: got %b want %b", target, dp.addr, rsp, dp.err ? 2'b01 : 2'b00);
        end
        if (rdy === 1'b1) begin
          checks++;
          if (waits != dp.waits) begin
            errors++;
            $display("FAIL wait_count t%0d addr=%h: got %0d want %0d", target, dp.addr, waits, dp.waits);
          end
          if (!dp.write && !dp.err && dp.check_rdata) begin
            checks++;
            if (rd !== dp.rdata) begin
              errors++;
              $display("FAIL rdata t%0d addr=%h: got %h want %h", target, dp.addr, rd, dp.rdata);
            end
          end else if (dp.write || dp.err) begin
            checks++;
            if (rd !== 32'h0) begin
              errors++;
              $display("FAIL rdata_zero t%0d addr=%h: got %h want 00000000", target, dp.addr, rd);
            end
          end
          $display("txn t%0d %s addr=%h wdata=%h rdata=%h resp=%b waits=%0d", target,
                   dp.write ? "WR" : "RD", dp.addr, dp.wdata, rd, rsp, waits);
          dp_valid = 1'b0;
        end else begin
          waits++;
        end
      end else if (rdy !== 1'b1 || rsp !== 2'b00 || rd !== 32'h0) begin
        errors++;
        $display("FAIL idle_outputs t%0d: got ready=%b resp=%b rdata=%h want 1 00 00000000", target, rdy, rsp, rd);
      end
      @(posedge hclk);
      if (rdy === 1'b1 && stim_q.size() > 0) begin
        t = stim_q.pop_front();
        e = exp_q.pop_front();
        if (e.active) begin
          dp = e; dp_valid = 1'b1; waits = 0;
        end else begin
          $display("txn t%0d no data phase sel=%b trans=%b addr=%h", target, t.sel, t.trans, t.addr);
        end
      end
      #1;
    end
    if (guard >= 500) begin
      checks++; errors++;
      $display("FAIL bus_timeout t%0d: got %0d cycles want completion", target, guard);
      stim_q.delete(); exp_q.delete();
    end
    drive_idle();
  endtask

  task automatic test_reset();
    drive_idle();
    hresetn = 1'b0;
    #3;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (hready_v[i] !== 1'b1 || hresp_v[i] !== 2'b00 || hrdata_v[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got ready=%b resp=%b rdata=%h want 1 00 00000000",
                 i, hready_v[i], hresp_v[i], hrdata_v[i]);
      end
    end
    $display("txn reset asserted");
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
  endtask

  task automatic test_back_to_back();
    target = 0;
    push(1, 2'b10, 1, 32'h10, 3'd2, 32'hDEADBEEF);
    push(1, 2'b10, 0, 32'h10, 3'd2, 32'h0);
    run_bus();
  endtask

  task automatic test_wait_states();
    target = 2;
    push(1, 2'b10, 1, 32'h30, 3'd2, 32'h5A5A1234);
    push(1, 2'b10, 0, 32'h30, 3'd2, 32'h0);
    run_bus();
  endtask

  task automatic test_byte_lanes();
    for (int t = 0; t < 4; t++) begin
      target = t;
      push(1, 2'b10, 1, 32'h20, 3'd2, 32'h11223344);
      push(1, 2'b11, 1, 32'h21, 3'd0, 32'h0000AA00);
      push(1, 2'b11, 1, 32'h22, 3'd1, 32'hBBCC0000);
      push(1, 2'b10, 0, 32'h20, 3'd2, 32'h0);
      push(1, 2'b10, 1, 32'h24, 3'd2, 32'h55667788);
      push(1, 2'b10, 1, 32'h27, 3'd0, 32'h99000000);
      push(1, 2'b10, 1, 32'h24, 3'd1, 32'h0000EEDD);
      push(1, 2'b10, 0, 32'h24, 3'd2, 32'h0);
      run_bus();
    end
  endtask

  task automatic test_errors();
    for (int t = 0; t < 4; t += 2) begin
      target = t;
      push(1, 2'b10, 1, 32'h00, 3'd2, 32'hCAFEF00D);
      push(1, 2'b10, 1, 32'h02, 3'd2, 32'hFFFFFFFF);
      push(1, 2'b10, 1, 32'h03, 3'd1, 32'hFFFFFFFF);
      push(1, 2'b10, 0, 32'h06, 3'd2, 32'h0);
      push(1, 2'b10, 1, 32'h00, 3'd3, 32'h01234567);
      push(1, 2'b10, 0, 32'h00, 3'd2, 32'h0);
      run_bus();
    end
  endtask

  task automatic test_reset_mid_wait();
    target = 3;
    push(1, 2'b10, 1, 32'h40, 3'd2, 32'h0BADF00D);
    run_bus();
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h40; hsize = 3'd2;
    @(posedge hclk);
    #1;
    drive_idle();
    hwdata = 32'h12345678;
    @(posedge hclk);
    #1;
    checks++;
    if (hready_v[3] !== 1'b0) begin
      errors++;
      $display("FAIL second_wait_ready: got %b want 0", hready_v[3]);
    end
    #1 hresetn = 1'b0;
    #1;
    checks++;
    if (hready_v[3] !== 1'b1 || hresp_v[3] !== 2'b00 || hrdata_v[3] !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_wait: got ready=%b resp=%b rdata=%h want 1 00 00000000",
               hready_v[3], hresp_v[3], hrdata_v[3]);
    end
    $display("txn t3 reset during second wait cycle of write to 00000040");
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    repeat (3) @(posedge hclk);
    #1;
    hwdata = 32'hFFFF_FFFF;
    push(1, 2'b10, 0, 32'h40, 3'd2, 32'h0);
    run_bus();
  endtask

  task automatic test_no_data_phase();
    target = 1;
    push(1, 2'b10, 1, 32'h50, 3'd2, 32'h600DCAFE);
    push(1, 2'b00, 1, 32'h50, 3'd2, 32'h11111111);
    push(1, 2'b01, 1, 32'h50, 3'd2, 32'h22222222);
    push(0, 2'b10, 1, 32'h50, 3'd2, 32'h33333333);
    push(1, 2'b10, 0, 32'h50, 3'd2, 32'h0);
    run_bus();
  endtask

  task automatic test_alias_and_mix();
    logic [31:0] d;
    for (int t = 0; t < 4; t++) begin
      target = t;
      push(1, 2'b10, 1, 32'hABCD_1060, 3'd2, 32'hA11A5ED0 + t);
      push(1, 2'b10, 0, 32'h0000_0060, 3'd2, 32'h0);
      for (int i = 0; i < 5; i++) begin
        d = $urandom;
        push(1, 2'b11, 1, 32'h100 + 4 * i, 3'd2, d);
      end
      for (int i = 4; i >= 0; i--) push(1, 2'b11, 0, 32'h100 + 4 * i, 3'd2, 32'h0);
      run_bus();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_byte_lanes();
    test_errors();
    test_reset_mid_wait();
    test_no_data_phase();
    test_alias_and_mix();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
